// File: rtl/pix_proc_pipe.sv
// Pixel processing pipeline: a DELAY-word delay line carrying {valid, addr, data}
// followed by one output register that applies a per-channel pixel operation.
module pix_proc_pipe #(
   parameter int unsigned NPIX   = 2,
   parameter int unsigned CW     = 6,
   parameter int unsigned AW     = 19,
   parameter int unsigned DELAY  = 150,
   parameter logic [CW-1:0] R_MASK = 6'b110000,
   parameter logic [CW-1:0] G_MASK = 6'b111000,
   parameter logic [CW-1:0] B_MASK = 6'b110000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [NPIX*3*CW-1:0]   in_data,
   input  logic [AW-1:0]          in_addr,
   input  logic [1:0]             mode,
   input  logic [CW-1:0]          thr_r,
   input  logic [CW-1:0]          thr_g,
   input  logic [CW-1:0]          thr_b,
   output logic                   out_valid,
   output logic [NPIX*3*CW-1:0]   out_data,
   output logic [AW-1:0]          out_addr,
   output logic [15:0]            out_count
);

   localparam int unsigned PW = 3 * CW;
   localparam int unsigned DW = NPIX * PW;

   // Delay line: only the valid bits are reset, so bubbles never turn into stale words.
   logic [DELAY-1:0] vld_q, vld_d;
   logic [DW-1:0]    dat_q [DELAY];
   logic [AW-1:0]    adr_q [DELAY];

   logic             out_valid_q;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic [AW-1:0]    out_addr_q;
   logic [15:0]      out_count_q, out_count_d;

   logic [CW-1:0]    r, g, b;
   logic [PW-1:0]    pix;

   // Next-state of the valid shift chain.
   always_comb begin
      vld_d    = vld_q;
      vld_d[0] = in_valid;
      for (int i = 1; i < int'(DELAY); i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   // Valid bits of the delay line, cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
      end else if (en) begin
         vld_q <= vld_d;
      end
   end

   // Data and address payload of the delay line; no reset needed.
   always_ff @(posedge clk) begin
      if (en) begin
         dat_q[0] <= in_data;
         adr_q[0] <= in_addr;
         for (int i = 1; i < int'(DELAY); i++) begin
            dat_q[i] <= dat_q[i-1];
            adr_q[i] <= adr_q[i-1];
         end
      end
   end

   // Pixel operation on the word leaving the delay line, per pixel and channel.
   always_comb begin
      out_data_d = '0;
      r          = '0;
      g          = '0;
      b          = '0;
      pix        = '0;
      for (int p = 0; p < int'(NPIX); p++) begin
         r = dat_q[DELAY-1][p*PW + 2*CW +: CW];
         g = dat_q[DELAY-1][p*PW + CW +: CW];
         b = dat_q[DELAY-1][p*PW +: CW];
         unique case (mode)
            2'b00:   pix = {r, g, b};
            2'b01:   pix = {r & R_MASK, g & G_MASK, b & B_MASK};
            2'b10:   pix = ((r >= thr_r) && (g >= thr_g) && (b >= thr_b)) ? '1 : '0;
            default: pix = ~{r, g, b};
         endcase
         out_data_d[p*PW +: PW] = pix;
      end
   end

   // Count only words that arrive at the output with valid set; wraps naturally.
   always_comb begin
      out_count_d = out_count_q;
      if (vld_q[DELAY-1]) begin
         out_count_d = out_count_q + 16'd1;
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_count_q <= '0;
      end else if (en) begin
         out_valid_q <= vld_q[DELAY-1];
         out_data_q  <= out_data_d;
         out_addr_q  <= adr_q[DELAY-1];
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_pix_proc_pipe.sv
// Directed bench for pix_proc_pipe (DELAY=4 main instance, DELAY=1 side instance).
module tb_pix_proc_pipe;

   localparam int unsigned DLY = 4;

   logic        clk;
   logic        reset;
   logic        en;
   logic        in_valid;
   logic [35:0] in_data;
   logic [18:0] in_addr;
   logic [1:0]  mode;
   logic [5:0]  thr_r, thr_g, thr_b;

   logic        out_valid,  out_valid1;
   logic [35:0] out_data,   out_data1;
   logic [18:0] out_addr,   out_addr1;
   logic [15:0] out_count,  out_count1;

   int n_cmp = 0;
   int n_err = 0;

   pix_proc_pipe #(.NPIX(2), .CW(6), .AW(19), .DELAY(DLY)) u_dut (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
      .in_addr(in_addr), .mode(mode), .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
      .out_count(out_count)
   );

   pix_proc_pipe #(.NPIX(2), .CW(6), .AW(19), .DELAY(1)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
      .in_addr(in_addr), .mode(mode), .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b),
      .out_valid(out_valid1), .out_data(out_data1), .out_addr(out_addr1),
      .out_count(out_count1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1ns after the rising edge.
   task automatic step(input logic e, input logic v, input logic [35:0] d, input logic [18:0] a);
      en       = e;
      in_valid = v;
      in_data  = d;
      in_addr  = a;
      @(posedge clk);
      #1;
   endtask

   // One valid word followed by enough bubbles to bring it to the output register.
   task automatic send_word(input logic [35:0] d, input logic [18:0] a);
      step(1'b1, 1'b1, d, a);
      repeat (DLY) step(1'b1, 1'b0, 36'h0, 19'h0);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   logic [10:0] stall_exp_v;

   initial begin
      reset    = 1'b0;
      en       = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_addr  = '0;
      mode     = 2'b00;
      thr_r    = 6'd8;
      thr_g    = 6'd8;
      thr_b    = 6'd8;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 64'(out_valid), 64'h0);
      check_eq("rst_data",  64'(out_data),  64'h0);
      check_eq("rst_addr",  64'(out_addr),  64'h0);
      check_eq("rst_count", 64'(out_count), 64'h0);
      @(negedge clk);
      reset = 1'b1;

      // Pass-through latency: DELAY=4 main, DELAY=1 side instance
      mode = 2'b00;
      step(1'b1, 1'b1, 36'h123456789, 19'd5);
      step(1'b1, 1'b0, 36'h0, 19'h0);
      check_eq("d1_valid", 64'(out_valid1), 64'h1);
      check_eq("d1_data",  64'(out_data1),  64'h123456789);
      check_eq("d1_addr",  64'(out_addr1),  64'd5);
      check_eq("early_valid0", 64'(out_valid), 64'h0);
      step(1'b1, 1'b0, 36'h0, 19'h0);
      check_eq("early_valid1", 64'(out_valid), 64'h0);
      step(1'b1, 1'b0, 36'h0, 19'h0);
      check_eq("early_valid2", 64'(out_valid), 64'h0);
      step(1'b1, 1'b0, 36'h0, 19'h0);
      check_eq("pass_valid", 64'(out_valid), 64'h1);
      check_eq("pass_data",  64'(out_data),  64'h123456789);
      check_eq("pass_addr",  64'(out_addr),  64'd5);
      check_eq("pass_count", 64'(out_count), 64'd1);

      // Quantise
      mode = 2'b01;
      send_word(36'hFFFFFFFFF, 19'd7);
      check_eq("quant_data",  64'(out_data),
               64'({6'h30, 6'h38, 6'h30, 6'h30, 6'h38, 6'h30}));
      check_eq("quant_count", 64'(out_count), 64'd2);

      // Threshold
      mode = 2'b10;
      send_word({6'd7, 6'd40, 6'd40, 6'd9, 6'd8, 6'd20}, 19'd9);
      check_eq("thr_data", 64'(out_data), 64'({18'h00000, 18'h3FFFF}));
      check_eq("thr_addr", 64'(out_addr), 64'd9);

      // Invert
      mode = 2'b11;
      send_word(36'h123456789, 19'd11);
      check_eq("inv_data",  64'(out_data),  64'hEDCBA9876);
      check_eq("inv_count", 64'(out_count), 64'd4);

      // en=0 freezes outputs even when mode and inputs change
      mode = 2'b00;
      repeat (3) step(1'b0, 1'b1, 36'h0, 19'd3);
      check_eq("hold_valid", 64'(out_valid), 64'h1);
      check_eq("hold_data",  64'(out_data),  64'hEDCBA9876);
      check_eq("hold_addr",  64'(out_addr),  64'd11);
      check_eq("hold_count", 64'(out_count), 64'd4);

      // Bubble still gets the operation but does not count
      mode = 2'b11;
      step(1'b1, 1'b0, 36'h0, 19'h0);
      check_eq("bub_valid", 64'(out_valid), 64'h0);
      check_eq("bub_data",  64'(out_data),  64'hFFFFFFFFF);
      check_eq("bub_count", 64'(out_count), 64'd4);

      // Stall: valid at cycles 0 and 2, en=0 at cycles 3..5
      mode        = 2'b00;
      stall_exp_v = 11'b010_1000_0000;
      for (int k = 0; k < 11; k++) begin
         step(!(k >= 3 && k <= 5), (k == 0) || (k >= 2 && k <= 5), 36'hABC, 19'(20 + k));
         check_eq($sformatf("stall_valid_k%0d", k), 64'(out_valid), 64'(stall_exp_v[k]));
         if (k == 7) check_eq("stall_addr_a", 64'(out_addr), 64'd20);
         if (k == 9) check_eq("stall_addr_b", 64'(out_addr), 64'd22);
      end
      check_eq("stall_count", 64'(out_count), 64'd6);

      // Asynchronous reset with words in flight
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 36'h55555555 + 36'(k), 19'(40 + k));
      check_eq("pre_rst_valid", 64'(out_valid), 64'h1);
      check_eq("pre_rst_count", 64'(out_count), 64'd7);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("arst_valid", 64'(out_valid), 64'h0);
      check_eq("arst_data",  64'(out_data),  64'h0);
      check_eq("arst_addr",  64'(out_addr),  64'h0);
      check_eq("arst_count", 64'(out_count), 64'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 36'h0, 19'h0);
         check_eq($sformatf("post_rst_valid_%0d", k), 64'(out_valid), 64'h0);
      end
      send_word(36'h000000FFF, 19'd60);
      check_eq("post_rst_new_valid", 64'(out_valid), 64'h1);
      check_eq("post_rst_new_count", 64'(out_count), 64'd1);

      // Counter wrap after 65537 valid words
      pulse_reset();
      for (int i = 0; i < 65541; i++) begin
         step(1'b1, i < 65537, 36'(i), 19'(i));
         if (i == 65538) check_eq("wrap_65535", 64'(out_count), 64'd65535);
         if (i == 65539) check_eq("wrap_0",     64'(out_count), 64'd0);
         if (i == 65540) check_eq("wrap_1",     64'(out_count), 64'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
